// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: round-robin collector of engine pixel results onto the
// single framebuffer write port, with iteration-to-palette mapping and a
// per-frame pixel counter.
module fb_write_arbiter #(
   parameter int NUM_ENGINES = 4,
   parameter int ADDR_BITS   = 20,
   parameter int ITER_BITS   = 16,
   parameter int DATA_BITS   = 4,
   parameter int PIXELS      = 1024*768
) (
   input  logic                             clk_calc,
   input  logic                             reset,
   input  logic                             frame_start,
   input  logic [ITER_BITS-1:0]             max_iter,
   input  logic [NUM_ENGINES-1:0]           eng_valid,
   output logic [NUM_ENGINES-1:0]           eng_ready,
   input  logic [NUM_ENGINES*ADDR_BITS-1:0] eng_addr,
   input  logic [NUM_ENGINES*ITER_BITS-1:0] eng_iter,
   output logic                             write_en,
   output logic [ADDR_BITS-1:0]             write_addr,
   output logic [DATA_BITS-1:0]             write_data,
   output logic [ADDR_BITS-1:0]             pixel_count,
   output logic                             frame_done
);

   localparam int PTR_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

   logic [PTR_W-1:0]     ptr;
   logic [PTR_W-1:0]     grant_idx;
   logic                 grant;
   logic [ADDR_BITS-1:0] sel_addr;
   logic [ITER_BITS-1:0] sel_iter;
   logic [ITER_BITS-1:0] iter_mod;
   logic [DATA_BITS-1:0] palette;
   logic [ADDR_BITS-1:0] cnt_base;
   logic [ADDR_BITS-1:0] cnt_inc;

   // Round-robin search starting at ptr; held off entirely during reset so
   // nothing is accepted while the block is being cleared.
   always_comb begin
      int idx;
      grant     = 1'b0;
      grant_idx = '0;
      eng_ready = '0;
      idx       = 0;
      if (!reset) begin
         for (int k = 0; k < NUM_ENGINES; k++) begin
            idx = (int'(ptr) + k) % NUM_ENGINES;
            if (!grant && eng_valid[idx]) begin
               grant     = 1'b1;
               grant_idx = PTR_W'(idx);
            end
         end
      end
      if (grant) eng_ready[grant_idx] = 1'b1;
   end

   // Select the granted engine's payload and map its iteration count to a
   // palette index; the mod is taken at full width before truncation.
   always_comb begin
      sel_addr = eng_addr[grant_idx*ADDR_BITS +: ADDR_BITS];
      sel_iter = eng_iter[grant_idx*ITER_BITS +: ITER_BITS];
      iter_mod = sel_iter % ITER_BITS'(15);
      if (sel_iter >= max_iter) palette = '0;
      else                      palette = DATA_BITS'(iter_mod + ITER_BITS'(1));
   end

   // frame_start clears the count first so a coinciding transfer becomes
   // pixel 1 of the new frame.
   always_comb begin
      cnt_base = frame_start ? '0 : pixel_count;
      cnt_inc  = cnt_base + ADDR_BITS'(1);
   end

   // Registered write port, pointer advance and frame accounting.
   always_ff @(posedge clk_calc) begin
      if (reset) begin
         ptr         <= '0;
         write_en    <= 1'b0;
         write_addr  <= '0;
         write_data  <= '0;
         pixel_count <= '0;
         frame_done  <= 1'b0;
      end else begin
         write_en   <= grant;
         frame_done <= 1'b0;
         if (grant) begin
            write_addr <= sel_addr;
            write_data <= palette;
            ptr        <= (int'(grant_idx) == NUM_ENGINES-1) ? '0 : grant_idx + PTR_W'(1);
            if (cnt_inc == ADDR_BITS'(PIXELS)) begin
               pixel_count <= '0;
               frame_done  <= 1'b1;
            end else begin
               pixel_count <= cnt_inc;
            end
         end else begin
            pixel_count <= cnt_base;
         end
      end
   end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter: directed vectors with hand-computed expectations,
// using a 16-pixel frame so frame completion is reachable quickly.
module tb_fb_write_arbiter;

   localparam int N  = 4;
   localparam int AB = 20;
   localparam int IB = 16;
   localparam int DB = 4;

   logic              clk_calc = 1'b0;
   logic              reset;
   logic              frame_start;
   logic [IB-1:0]     max_iter;
   logic [N-1:0]      eng_valid;
   logic [N-1:0]      eng_ready;
   logic [N*AB-1:0]   eng_addr;
   logic [N*IB-1:0]   eng_iter;
   logic              write_en;
   logic [AB-1:0]     write_addr;
   logic [DB-1:0]     write_data;
   logic [AB-1:0]     pixel_count;
   logic              frame_done;

   int nvec = 0;
   int nerr = 0;

   // iter per engine: 0, 14, 15, 99 with max_iter=100 -> 1, 15, 1, 10
   logic [3:0] exp_d [N] = '{4'd1, 4'd15, 4'd1, 4'd10};

   fb_write_arbiter #(.NUM_ENGINES(N), .ADDR_BITS(AB), .ITER_BITS(IB),
                      .DATA_BITS(DB), .PIXELS(16)) dut (
      .clk_calc(clk_calc), .reset(reset), .frame_start(frame_start),
      .max_iter(max_iter), .eng_valid(eng_valid), .eng_ready(eng_ready),
      .eng_addr(eng_addr), .eng_iter(eng_iter), .write_en(write_en),
      .write_addr(write_addr), .write_data(write_data),
      .pixel_count(pixel_count), .frame_done(frame_done));

   always #5 clk_calc = ~clk_calc;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One cycle: drive, check combinational ready, clock, check registered outputs.
   task automatic cyc(input logic [N-1:0] v, input logic fs, input logic [N-1:0] er,
                      input int g, input logic [3:0] ed, input int ec, input logic efd);
      eng_valid   = v;
      frame_start = fs;
      #1;
      chk("ready", 32'(eng_ready), 32'(er));
      @(posedge clk_calc); #1;
      chk("wen", 32'(write_en), (g >= 0) ? 32'd1 : 32'd0);
      if (g >= 0) begin
         chk("waddr", 32'(write_addr), 32'h100 + 32'(g));
         chk("wdata", 32'(write_data), 32'(ed));
      end
      chk("count", 32'(pixel_count), 32'(ec));
      chk("done", 32'(frame_done), 32'(efd));
      frame_start = 1'b0;
   endtask

   initial begin
      int p, c;
      reset       = 1'b1;
      frame_start = 1'b0;
      max_iter    = 16'd100;
      eng_valid   = '1;
      for (int i = 0; i < N; i++) eng_addr[i*AB +: AB] = 20'h100 + 20'(i);
      eng_iter = {16'd99, 16'd15, 16'd14, 16'd0};

      // Reset held 3 cycles with all engines valid
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("rst_ready", 32'(eng_ready), 32'd0);
         @(posedge clk_calc); #1;
         chk("rst_wen", 32'(write_en), 32'd0);
         chk("rst_count", 32'(pixel_count), 32'd0);
         chk("rst_waddr", 32'(write_addr), 32'd0);
         chk("rst_wdata", 32'(write_data), 32'd0);
         chk("rst_done", 32'(frame_done), 32'd0);
      end
      reset = 1'b0;

      // Round-robin, all valid: 0,1,2,3,0,1,2,3
      for (int k = 0; k < 8; k++)
         cyc('1, 1'b0, 4'(1 << (k % 4)), k % 4, exp_d[k % 4], k + 1, 1'b0);

      // Skip idle engines: get ptr to 1, then only 0 and 3 valid
      cyc(4'b0001, 1'b0, 4'b0001, 0, exp_d[0], 9, 1'b0);
      cyc(4'b1001, 1'b0, 4'b1000, 3, exp_d[3], 10, 1'b0);
      cyc(4'b1001, 1'b0, 4'b0001, 0, exp_d[0], 11, 1'b0);
      cyc(4'b1001, 1'b0, 4'b1000, 3, exp_d[3], 12, 1'b0);
      cyc(4'b0000, 1'b0, 4'b0000, -1, 4'd0, 12, 1'b0);

      // Inside-set mapping: iter == max_iter and iter > max_iter -> 0
      eng_iter[2*IB +: IB] = 16'd100;
      cyc(4'b0100, 1'b0, 4'b0100, 2, 4'd0, 13, 1'b0);
      eng_iter[2*IB +: IB] = 16'd250;
      cyc(4'b0100, 1'b0, 4'b0100, 2, 4'd0, 14, 1'b0);
      eng_iter[2*IB +: IB] = 16'd15;

      // Clear the count with an idle frame_start (ptr is now 3)
      cyc(4'b0000, 1'b1, 4'b0000, -1, 4'd0, 0, 1'b0);

      // Full 16-pixel frame: done with the 16th write, count wraps to 0
      p = 3;
      for (int k = 0; k < 16; k++) begin
         c = (p + k) % 4;
         cyc('1, 1'b0, 4'(1 << c), c, exp_d[c], (k == 15) ? 0 : k + 1, k == 15);
      end
      cyc(4'b0000, 1'b0, 4'b0000, -1, 4'd0, 0, 1'b0);

      // frame_start colliding with the 8th transfer counts it as pixel 1
      p = 3;
      for (int k = 0; k < 7; k++) begin
         c = (p + k) % 4;
         cyc('1, 1'b0, 4'(1 << c), c, exp_d[c], k + 1, 1'b0);
      end
      c = (p + 7) % 4;
      cyc('1, 1'b1, 4'(1 << c), c, exp_d[c], 1, 1'b0);
      for (int k = 0; k < 15; k++) begin
         c = (p + 8 + k) % 4;
         cyc('1, 1'b0, 4'(1 << c), c, exp_d[c], (k == 14) ? 0 : k + 2, k == 14);
      end

      // Reset asserted right after a transfer drops the pending write
      eng_valid = '1;
      @(posedge clk_calc); #1;
      reset = 1'b1;
      @(posedge clk_calc); #1;
      chk("rst_drop_wen", 32'(write_en), 32'd0);
      chk("rst_drop_count", 32'(pixel_count), 32'd0);
      reset = 1'b0;
      eng_valid = '0;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
